// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard / stall / flush controller for a short in-order
// pipeline (IF, ID, EX, WB).
//
// Keeps a shadow copy of the destination-register bookkeeping for the EX and
// WB stages and combines it with the instruction currently in ID to decide
// stalls, bubbles, flushes and operand forwarding.  Multiply instructions
// occupy EX for MUL_CYCLES cycles; a taken branch flushes IF-ID for two
// cycles.
//
// Build option: define PIPE_HAZARD_CTRL_FWD_EN to enable operand forwarding
// (only load-use then stalls).  Without it fwd_a/fwd_b stay 00 and every
// RAW dependency on EX or WB stalls until the producer has left WB.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID stage holds a valid instruction
//   id_rs1, id_rs2, id_rd    ID source / destination register addresses
//   id_we                    ID instruction writes id_rd
//   id_is_load, id_is_mul    ID instruction is a load / multi-cycle multiply
//   ex_branch_taken          EX resolved a taken branch this cycle
//   pc_stall, if_id_stall    hold PC / hold IF-ID
//   id_ex_bubble             load a NOP into ID-EX
//   if_id_flush              replace IF-ID contents with NOP
//   fwd_a, fwd_b             operand source: 00 regfile, 01 EX, 10 WB
//   ex_busy                  multiply occupying EX
//   stall_cnt                saturating count of pc_stall cycles
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 3,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_busy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic              ex_we_q, ex_we_d, ex_load_q, ex_load_d, ex_vld_q, ex_vld_d;
  logic              wb_we_q, wb_we_d, wb_vld_q, wb_vld_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              a_ex, b_ex, a_wb, b_wb, hazard;
  logic              stall_int, bubble_int, flush_int, busy_int;
  logic [1:0]        fwd_a_int, fwd_b_int;

  function automatic logic hit(input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] rd,
                               input logic              vld,
                               input logic              we);
    return (src != '0) && (src == rd) && vld && we;
  endfunction

  always_comb begin
    a_ex = hit(id_rs1, ex_rd_q, ex_vld_q, ex_we_q);
    b_ex = hit(id_rs2, ex_rd_q, ex_vld_q, ex_we_q);
    a_wb = hit(id_rs1, wb_rd_q, wb_vld_q, wb_we_q);
    b_wb = hit(id_rs2, wb_rd_q, wb_vld_q, wb_we_q);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    // A load result is not available from EX, so a load match falls
    // through to the WB check (and stalls via hazard).
    hazard    = id_valid && ex_load_q && (a_ex || b_ex);
    fwd_a_int = (a_ex && !ex_load_q) ? 2'b01 : (a_wb ? 2'b10 : 2'b00);
    fwd_b_int = (b_ex && !ex_load_q) ? 2'b01 : (b_wb ? 2'b10 : 2'b00);
`else
    hazard    = id_valid && (a_ex || b_ex || a_wb || b_wb);
    fwd_a_int = 2'b00;
    fwd_b_int = 2'b00;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_int  = 1'b0;
    bubble_int = 1'b0;
    flush_int  = 1'b0;
    busy_int   = 1'b0;

    unique case (state_q)
      RUN: begin
        // A taken branch discards the ID instruction, so it overrides any
        // stall that instruction would otherwise cause.
        if (ex_branch_taken) begin
          flush_int  = 1'b1;
          bubble_int = 1'b1;
          state_d    = FLUSH;
        end else if (hazard) begin
          stall_int  = 1'b1;
          bubble_int = 1'b1;
        end else if (id_valid && id_is_mul) begin
          cnt_d   = MUL_LOAD;
          state_d = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        stall_int = 1'b1;
        busy_int  = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_int = 1'b1;
        state_d   = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Shadow pipeline: EX is frozen while the multiply occupies it.
    ex_rd_d   = ex_rd_q;
    ex_we_d   = ex_we_q;
    ex_load_d = ex_load_q;
    ex_vld_d  = ex_vld_q;
    wb_rd_d   = ex_rd_q;
    wb_we_d   = ex_we_q;
    wb_vld_d  = ex_vld_q;
    if (state_q == MUL_WAIT) begin
      wb_we_d  = 1'b0;
      wb_vld_d = 1'b0;
    end else begin
      ex_rd_d   = id_rd;
      ex_vld_d  = id_valid && !bubble_int;
      ex_we_d   = id_valid && !bubble_int && id_we;
      ex_load_d = id_valid && !bubble_int && id_is_load;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of state.
  always_comb begin
    pc_stall     = stall_int && !rst;
    if_id_stall  = stall_int && !rst;
    id_ex_bubble = bubble_int && !rst;
    if_id_flush  = flush_int && !rst;
    ex_busy      = busy_int && !rst;
    fwd_a        = rst ? 2'b00 : fwd_a_int;
    fwd_b        = rst ? 2'b00 : fwd_b_int;
    stall_cnt    = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_vld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_vld_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      ex_vld_q    <= ex_vld_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_vld_q    <= wb_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
